// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - op codes and FSM states shared by the arbiter slice
package logic_unit_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 5;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - two requester channels and the result channel
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready
    );
endinterface

// File: rtl/logic_unit_arbiter_bitwise_logic_unit.sv
// rtl/logic_unit_arbiter_bitwise_logic_unit.sv - combinational AND/OR/XOR/NOR unit
module bitwise_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] and_y;

    // AND slice kept separate so it stays the same cell the datapath already uses
    assign and_y = a & b;

    always_comb begin
        y = and_y;
        case (op)
            OP_AND:  y = and_y;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin share of one logic unit with a one-entry result slot
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    logic_unit_arbiter_if.slave  bus
);
    state_e           state, state_next;
    logic             prio;
    logic             slot_free;
    logic             grant0, grant1;
    logic             accept;
    logic             sel_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] unit_y;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        slot_free  = (state == EMPTY) || bus.res_ready;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = !prio;
            grant1 = prio;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
        // a draining slot with nothing to refill goes empty; a blocked slot stays full
        if (accept)
            state_next = FULL;
        else if (slot_free)
            state_next = EMPTY;
    end

    assign bus.req0_ready = slot_free && grant0 && !reset;
    assign bus.req1_ready = slot_free && grant1 && !reset;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign sel_id         = grant1;
    assign sel_op         = sel_id ? bus.req1_op : bus.req0_op;
    assign sel_a          = sel_id ? bus.req1_a  : bus.req0_a;
    assign sel_b          = sel_id ? bus.req1_b  : bus.req0_b;

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_unit (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (unit_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            prio       <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                res_data_q <= unit_y;
                res_id_q   <= sel_id;
                prio       <= !sel_id;
            end
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized and directed check of logic_unit_arbiter against a reference model
module tb_logic_unit_arbiter;
    localparam int W = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic_unit_arbiter_if #(.WIDTH(W)) bus ();

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // reference model: slot contents, priority holder, and queue of results owed to the consumer
    bit             m_full;
    bit             m_prio;
    bit             m_id;
    logic [W-1:0]   m_data;
    logic [W:0]     owed[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int ai = a, bi = b, r;
        case (op)
            2'd0:    r = ai & bi;
            2'd1:    r = ai | bi;
            2'd2:    r = ai ^ bi;
            default: r = (2 ** W - 1) - (ai | bi);
        endcase
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_full = 0; m_prio = 0; m_id = 0; m_data = '0;
        owed.delete();
    endtask

    task automatic set_idle();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    endtask

    // entered at posedge+1 with inputs already driven; leaves at the next posedge+1
    task automatic cycle();
        bit         v0, v1, sf, g, gid;
        logic [W:0] head;
        logic [W-1:0] r;
        #3;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        sf  = !m_full || bus.res_ready;
        g   = sf && (v0 || v1);
        gid = (v0 && v1) ? m_prio : !v0;
        check("req0_ready", bus.req0_ready, g && !gid);
        check("req1_ready", bus.req1_ready, g && gid);
        check("res_valid", bus.res_valid, m_full);
        check("res_data", bus.res_data, m_data);
        check("res_id", bus.res_id, m_id);
        if (bus.res_valid && bus.res_ready) begin
            check("owed_count", owed.size(), 1);
            if (owed.size() != 0) begin
                head = owed.pop_front();
                check("consume_order", {bus.res_id, bus.res_data}, head);
            end
        end
        r = gid ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
        if (g) owed.push_back({gid, r});
        @(posedge clk);
        #1;
        if (g) begin
            m_full = 1; m_data = r; m_id = gid; m_prio = !gid;
        end else if (sf) begin
            m_full = 0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1;
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1;
        set_idle();
        bus.res_ready  = 0;
        model_reset();
        bus.req0_valid = 1;
        #2;
        check("ready_in_reset", bus.req0_ready, 0);
        bus.req0_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;

        // idle after reset
        for (int i = 0; i < 2; i++) cycle();
        check("idle_data", bus.res_data, 5'b00000);

        // single requester AND
        bus.res_ready  = 1;
        bus.req0_valid = 1; bus.req0_op = 2'b00; bus.req0_a = 5'b11111; bus.req0_b = 5'b00111;
        #2;
        check("and_ready0", bus.req0_ready, 1);
        cycle();
        set_idle();
        #2;
        check("and_data", bus.res_data, 5'b00111);
        check("and_id", bus.res_id, 0);
        cycle();

        // both valid: grants alternate starting with req0
        pulse_reset();
        bus.res_ready  = 1;
        bus.req0_valid = 1; bus.req0_op = 2'b10; bus.req0_a = 5'b11000; bus.req0_b = 5'b11000;
        bus.req1_valid = 1; bus.req1_op = 2'b01; bus.req1_a = 5'b10000; bus.req1_b = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("alt_grant0", bus.req0_ready, (i % 2) == 0);
            if (i > 0) begin
                check("alt_data", bus.res_data, (i % 2) ? 5'b00000 : 5'b10010);
                check("alt_id", bus.res_id, (i % 2) ? 0 : 1);
            end
            cycle();
        end

        // backpressure then same-cycle drain and refill
        bus.res_ready = 0;
        for (int i = 0; i < 3; i++) cycle();
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_op = 2'b11; bus.req1_a = 5'b00000; bus.req1_b = 5'b00000;
        bus.res_ready  = 1;
        #2;
        check("bp_accept1", bus.req1_ready, 1);
        cycle();
        set_idle();
        #2;
        check("nor_data", bus.res_data, 5'b11111);
        check("nor_id", bus.res_id, 1);
        cycle();

        // reset while full with both requesters waiting
        bus.res_ready  = 1;
        bus.req0_valid = 1; bus.req0_op = 2'b01; bus.req0_a = 5'b00101; bus.req0_b = 5'b01000;
        cycle();
        bus.res_ready  = 0;
        bus.req1_valid = 1; bus.req1_op = 2'b00; bus.req1_a = 5'b11111; bus.req1_b = 5'b10101;
        cycle();
        check("full_before_reset", bus.res_valid, 1);
        pulse_reset();
        bus.res_ready = 1;
        #2;
        check("post_reset_grant0", bus.req0_ready, 1);
        check("post_reset_grant1", bus.req1_ready, 0);
        cycle();

        // random sweep
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = ($urandom_range(0, 99) < 60);
            bus.req0_op    = 2'($urandom);
            bus.req0_a     = W'($urandom);
            bus.req0_b     = W'($urandom);
            bus.req1_valid = ($urandom_range(0, 99) < 60);
            bus.req1_op    = 2'($urandom);
            bus.req1_a     = W'($urandom);
            bus.req1_b     = W'($urandom);
            bus.res_ready  = ($urandom_range(0, 99) < 70);
            cycle();
        end

        // drain and confirm nothing is left owed
        set_idle();
        bus.res_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        check("drain_empty", owed.size(), 0);
        check("drain_valid", bus.res_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
